gf_mult_arbiter: RTL and testbench



---
 rtl/gf_mult_arbiter_pkg.sv | 28 ++
 rtl/gf_mult_arbiter_if.sv | 39 +++
 rtl/gf_mult_arbiter_rr_arbiter.sv | 35 +++
 rtl/gf_mult_arbiter.sv | 136 +++++++++++++
 tb/tb_gf_mult_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_mult_arbiter_pkg.sv
// gf_mult_arbiter_pkg
// Shared constants for the GF(2^m) multiplier arbiter and the multiplier it
// fronts: default field width, the reduction polynomial's low terms and the
// sequencer state encoding.
package gf_mult_arbiter_pkg;

  // Field width used by the ECC core.
  localparam int M_DEFAULT = 163;

  // Low-order terms of p(x) = x^163 + x^7 + x^6 + x^3 + 1 (x^163 implied).
  localparam logic [M_DEFAULT-1:0] GF_POLY = M_DEFAULT'('hC9);

  // Sequencer state encoding.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_WAIT  = WAIT,
    S_RESP  = RESP,
    S_GAP   = GAP
  } state_t;

endpackage

// File: rtl/gf_mult_arbiter_if.sv
// gf_mult_arbiter_if
// Bundles the requester side (req/op_a/op_b/gnt, response channel) and the
// multiplier side (mul_*) of the shared GF multiplier arbiter.
//   slave  : the arbiter's view (drives gnt, rsp_*, busy, mul_a/b, mul_start)
//   master : the requesters' and multiplier's view (drives req, op_a/b,
//            rsp_ready, mul_done, mul_z)
interface gf_mult_arbiter_if
  import gf_mult_arbiter_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*M-1:0] op_a;
  logic [N_REQ*M-1:0] op_b;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [M-1:0]       rsp_z;
  logic               rsp_err;
  logic               busy;
  logic [M-1:0]       mul_a;
  logic [M-1:0]       mul_b;
  logic               mul_start;
  logic               mul_done;
  logic [M-1:0]       mul_z;

  modport master (
    output req, op_a, op_b, rsp_ready, mul_done, mul_z,
    input  gnt, rsp_valid, rsp_z, rsp_err, busy, mul_a, mul_b, mul_start
  );

  modport slave (
    input  req, op_a, op_b, rsp_ready, mul_done, mul_z,
    output gnt, rsp_valid, rsp_z, rsp_err, busy, mul_a, mul_b, mul_start
  );

endinterface

// File: rtl/gf_mult_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. Requests at or above ptr take priority;
// if none exist the search wraps to the lowest raw request.
//   req : request vector
//   ptr : index with highest priority this round
//   win : selected requester index (0 when no request)
//   any : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   win,
  output logic             any
);

  logic [N_REQ-1:0] masked;

  // Descending scans so the last assignment is the lowest index; the masked
  // scan runs second so it overrides the wrapped fallback whenever it hits.
  always_comb begin
    masked = '0;
    win    = '0;
    for (int i = 0; i < N_REQ; i++)
      masked[i] = req[i] && (i >= int'(ptr));
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) win = IDW'(i);
    for (int i = N_REQ - 1; i >= 0; i--)
      if (masked[i]) win = IDW'(i);
  end

  assign any = |req;

endmodule

// File: rtl/gf_mult_arbiter.sv
// gf_mult_arbiter
// Shares one GF(2^m) multiplier among N_REQ requesters. A round-robin winner
// is granted for one cycle, its operands are latched onto mul_a/mul_b, the
// multiplier is driven with a level-held start until its done pulse, and the
// product goes back to the winner over a valid/ready channel. A watchdog
// aborts with rsp_err=1 and rsp_z=0 if done never arrives.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester and multiplier signals (slave modport)
// All outputs are registered.
module gf_mult_arbiter
  import gf_mult_arbiter_pkg::*;
#(
  parameter int M       = M_DEFAULT,
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  gf_mult_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, owner_q, win;
  logic             any_req;
  logic [7:0]       wd_q;
  logic             grant_en, done_en, expire_en, ack_en;
  logic [N_REQ-1:0] gnt_q, rsp_valid_q;
  logic [M-1:0]     rsp_z_q, mul_a_q, mul_b_q;
  logic             rsp_err_q, busy_q, mul_start_q;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
    .req (bus.req),
    .ptr (ptr_q),
    .win (win),
    .any (any_req)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus one-cycle strobes for the datapath. In WAIT a done pulse
  // is checked before watchdog expiry so done wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    grant_en  = 1'b0;
    done_en   = 1'b0;
    expire_en = 1'b0;
    ack_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mul_done) begin
          done_en = 1'b1;
          state_d = S_RESP;
        end else if (wd_q == 8'(TIMEOUT)) begin
          expire_en = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          ack_en  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, operand/result latches and watchdog. mul_start and
  // busy are derived from the next state so they line up with the state they
  // describe; mul_start therefore rises on the first WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
    end else begin
      gnt_q       <= '0;
      busy_q      <= (state_d != S_IDLE);
      mul_start_q <= (state_d == S_WAIT);

      if (grant_en) begin
        gnt_q   <= N_REQ'(1) << win;
        owner_q <= win;
        ptr_q   <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
        mul_a_q <= bus.op_a[int'(win)*M +: M];
        mul_b_q <= bus.op_b[int'(win)*M +: M];
      end

      if (state_q == S_ISSUE)     wd_q <= '0;
      else if (state_q == S_WAIT) wd_q <= wd_q + 8'd1;

      if (done_en) begin
        rsp_z_q     <= bus.mul_z;
        rsp_err_q   <= 1'b0;
        rsp_valid_q <= N_REQ'(1) << owner_q;
      end else if (expire_en) begin
        rsp_z_q     <= '0;
        rsp_err_q   <= 1'b1;
        rsp_valid_q <= N_REQ'(1) << owner_q;
      end else if (ack_en) begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_start = mul_start_q;

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// tb_gf_mult_arbiter
// Bench for gf_mult_arbiter: a behavioural multiplier with programmable
// latency (or no done at all), requester drivers, and a scoreboard whose
// expected responses are pushed at grant time from a cyclic round-robin
// model and a bit-serial GF(2^163) product.
module tb_gf_mult_arbiter;
  import gf_mult_arbiter_pkg::*;

  localparam int M       = 163;
  localparam int N_REQ   = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 255;

  typedef struct {
    int           idx;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] z;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gf_mult_arbiter_if #(.M(M), .N_REQ(N_REQ)) bus ();

  gf_mult_arbiter #(.M(M), .N_REQ(N_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           checks = 0;
  int           failures = 0;
  exp_t         exp_q[$];
  int           gnt_order[$];
  int           exp_order[$];
  int           model_ptr = 0;
  logic [N_REQ-1:0] last_req = '0;
  int           cyc = 0;
  int           last_gnt_cycle = -1, start_cycle = -1, done_cycle = -1, last_ack_cycle = -1;
  logic [N_REQ-1:0] prev_gnt = '0, prev_valid = '0;
  logic         prev_start = 1'b0;
  int           mul_latency = 5;
  bit           never_done = 1'b0;
  bit           hold_ready = 1'b0;
  bit           random_mode = 1'b0;
  int           jobs_left[N_REQ];
  logic [M-1:0] op_a_v[N_REQ];
  logic [M-1:0] op_b_v[N_REQ];
  logic [M-1:0] last_rsp_z = '0;
  logic         last_rsp_err = 1'b0;

  // GF(2^163) product straight from the definition: shift-and-add of a by
  // the bits of b, reducing by p(x) whenever the x^163 term appears.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = r[M-1] ? ((r << 1) ^ GF_POLY) : (r << 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] randWide();
    return M'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Cyclic search from p for the first pending requester.
  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  function automatic int idxOf(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int jobsPending();
    int s = 0;
    for (int i = 0; i < N_REQ; i++) s += jobs_left[i];
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [M-1:0] act, input logic [M-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [M-1:0] a, input logic [M-1:0] b);
    op_a_v[idx] = a;
    op_b_v[idx] = b;
    bus.op_a[idx*M +: M] = a;
    bus.op_b[idx*M +: M] = b;
    bus.req[idx] = 1'b1;
  endtask

  // Per-cycle requester behaviour: drop req on its grant, re-raise while
  // jobs remain, and drive rsp_ready (owner bit masked under backpressure).
  task automatic driveCycle();
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.gnt[i]) bus.req[i] = 1'b0;
      else if (!bus.req[i] && jobs_left[i] > 0 && !rst) begin
        jobs_left[i]--;
        applyStimulus(i, randWide(), randWide());
      end
    end
    if (hold_ready) bus.rsp_ready = N_REQ'($urandom()) & ~bus.rsp_valid;
    else            bus.rsp_ready = N_REQ'($urandom());
    if (random_mode) mul_latency = $urandom_range(1, 12);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    driveCycle();
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    step();
    while (!(bus.req == '0 && exp_q.size() == 0 && !bus.busy && jobsPending() == 0) && n < limit) begin
      step();
      n++;
    end
    checkInt({name, "_finished"}, int'(n < limit), 1);
  endtask

  task automatic checkOrder(input string name);
    checkInt({name, "_count"}, gnt_order.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < gnt_order.size(); i++)
      checkInt({name, "_order"}, gnt_order[i], exp_order[i]);
  endtask

  task automatic checkReset(input string tag);
    checkInt({tag, "_gnt"}, int'(bus.gnt), 0);
    checkInt({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    checkInt({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
    checkInt({tag, "_busy"}, int'(bus.busy), 0);
    checkInt({tag, "_mul_start"}, int'(bus.mul_start), 0);
    checkOutput({tag, "_rsp_z"}, bus.rsp_z, '0);
    checkOutput({tag, "_mul_a"}, bus.mul_a, '0);
    checkOutput({tag, "_mul_b"}, bus.mul_b, '0);
  endtask

  // Behavioural multiplier: counts cycles of a held start and pulses done
  // with the product once the latency has elapsed (never, if never_done).
  initial begin : mult_model
    int cnt;
    bit served;
    cnt = 0;
    served = 1'b0;
    bus.mul_done = 1'b0;
    bus.mul_z = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mul_done = 1'b0;
      if (rst || !bus.mul_start) begin
        cnt = 0;
        served = 1'b0;
      end else if (!served) begin
        cnt++;
        if (!never_done && cnt >= mul_latency) begin
          bus.mul_done = 1'b1;
          bus.mul_z = gf_mul(bus.mul_a, bus.mul_b);
          served = 1'b1;
        end
      end
    end
  end

  // Monitor and scoreboard, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   w;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_ptr = 0;
      prev_gnt = '0;
      prev_valid = '0;
      prev_start = 1'b0;
      last_ack_cycle = -1;
    end else begin
      if (bus.gnt != '0) begin
        w = pick(last_req, model_ptr);
        checkInt("gnt_onehot", $countones(bus.gnt), 1);
        checkInt("gnt_single_cycle", int'(prev_gnt), 0);
        checkInt("gnt_index", idxOf(bus.gnt), w);
        checkInt("gnt_prev_resp_done", exp_q.size(), 0);
        if (last_ack_cycle >= 0)
          checkInt("gnt_after_gap", int'(cyc - last_ack_cycle >= 3), 1);
        gnt_order.push_back(idxOf(bus.gnt));
        last_gnt_cycle = cyc;
        if (w >= 0) begin
          e.idx = w;
          e.a   = op_a_v[w];
          e.b   = op_b_v[w];
          e.err = never_done;
          e.z   = never_done ? '0 : gf_mul(op_a_v[w], op_b_v[w]);
          exp_q.push_back(e);
          model_ptr = (w + 1) % N_REQ;
        end
      end

      if (bus.mul_start && !prev_start) begin
        checkInt("start_after_gnt", cyc - last_gnt_cycle, 1);
        start_cycle = cyc;
      end
      if (bus.mul_start && exp_q.size() > 0) begin
        checkOutput("mul_a", bus.mul_a, exp_q[0].a);
        checkOutput("mul_b", bus.mul_b, exp_q[0].b);
      end
      if (bus.mul_done) done_cycle = cyc;

      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rsp_unexpected: got valid %0b with no outstanding grant", bus.rsp_valid);
        end else begin
          e = exp_q[0];
          checkInt("rsp_valid_owner", int'(bus.rsp_valid), 1 << e.idx);
          checkOutput("rsp_z", bus.rsp_z, e.z);
          checkInt("rsp_err", int'(bus.rsp_err), int'(e.err));
          checkInt("resp_start_low", int'(bus.mul_start), 0);
          checkInt("resp_busy", int'(bus.busy), 1);
          if (prev_valid == '0) begin
            if (e.err) checkInt("timeout_latency", cyc - start_cycle, TIMEOUT + 1);
            else       checkInt("done_to_valid", cyc - done_cycle, 1);
          end
          if (bus.rsp_ready[e.idx]) begin
            last_rsp_z = bus.rsp_z;
            last_rsp_err = bus.rsp_err;
            last_ack_cycle = cyc;
            void'(exp_q.pop_front());
          end
        end
      end else if (prev_valid != '0) begin
        checkInt("gap_start_low", int'(bus.mul_start), 0);
        checkInt("gap_busy", int'(bus.busy), 1);
      end

      prev_gnt = bus.gnt;
      prev_valid = bus.rsp_valid;
      prev_start = bus.mul_start;
    end
    last_req = bus.req;
  end

  initial begin : guard
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got stuck at t=%0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin : main
    int n;
    for (int i = 0; i < N_REQ; i++) begin
      jobs_left[i] = 0;
      op_a_v[i] = '0;
      op_b_v[i] = '0;
    end
    bus.req = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.rsp_ready = '0;

    // Power-on reset.
    #2 rst = 1'b1;
    #1 checkReset("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All four requesting continuously from ptr=0: order 0,1,2,3,0.
    $display("[TB] all four requesters");
    gnt_order.delete();
    mul_latency = 5;
    jobs_left[0] = 2; jobs_left[1] = 1; jobs_left[2] = 1; jobs_left[3] = 1;
    waitIdle("all_four", 2000);
    exp_order.delete();
    exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
    exp_order.push_back(3); exp_order.push_back(0);
    checkOrder("all_four");

    // Single request with a 170-cycle multiplier.
    $display("[TB] single request");
    gnt_order.delete();
    mul_latency = 170;
    applyStimulus(0, M'(1), M'('hC9));
    waitIdle("single", 1000);
    checkOutput("single_z", last_rsp_z, M'('hC9));
    checkInt("single_err", int'(last_rsp_err), 0);
    exp_order.delete();
    exp_order.push_back(0);
    checkOrder("single");

    // Wrap and skip: serve 2 to move ptr to 3, then 0101 gives 0 then 2.
    $display("[TB] wrap and skip");
    gnt_order.delete();
    mul_latency = 7;
    applyStimulus(2, randWide(), randWide());
    waitIdle("wrap_setup", 1000);
    applyStimulus(0, randWide(), randWide());
    applyStimulus(2, randWide(), randWide());
    waitIdle("wrap", 1000);
    exp_order.delete();
    exp_order.push_back(2); exp_order.push_back(0); exp_order.push_back(2);
    checkOrder("wrap");

    // Timeout, then normal service.
    $display("[TB] timeout");
    never_done = 1'b1;
    applyStimulus(1, randWide(), randWide());
    waitIdle("timeout", 1000);
    never_done = 1'b0;
    checkInt("timeout_err_seen", int'(last_rsp_err), 1);
    checkOutput("timeout_z_zero", last_rsp_z, '0);
    mul_latency = 9;
    applyStimulus(3, randWide(), randWide());
    waitIdle("after_timeout", 1000);
    checkInt("after_timeout_err", int'(last_rsp_err), 0);

    // Response backpressure for 20 cycles with another request pending.
    $display("[TB] backpressure");
    hold_ready = 1'b1;
    mul_latency = 10;
    applyStimulus(0, randWide(), randWide());
    n = 0;
    step();
    while (bus.rsp_valid == '0 && n < 200) begin
      step();
      n++;
    end
    checkInt("bp_valid_seen", int'(bus.rsp_valid != '0), 1);
    applyStimulus(1, randWide(), randWide());
    repeat (20) begin
      step();
      checkInt("bp_no_gnt", int'(bus.gnt), 0);
      checkInt("bp_busy", int'(bus.busy), 1);
      checkInt("bp_valid_held", int'(bus.rsp_valid), 1);
    end
    hold_ready = 1'b0;
    waitIdle("backpressure", 1000);

    // Reset in the middle of WAIT with 1 and 3 pending.
    $display("[TB] reset mid-wait");
    mul_latency = 170;
    applyStimulus(2, randWide(), randWide());
    repeat (30) step();
    checkInt("pre_reset_start", int'(bus.mul_start), 1);
    applyStimulus(1, randWide(), randWide());
    applyStimulus(3, randWide(), randWide());
    repeat (5) step();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkReset("mid_wait");
    gnt_order.delete();
    mul_latency = 6;
    repeat (2) step();
    rst = 1'b0;
    waitIdle("post_reset", 1000);
    exp_order.delete();
    exp_order.push_back(1); exp_order.push_back(3);
    checkOrder("post_reset");

    // Randomised traffic with varying latency and ready.
    $display("[TB] random traffic");
    random_mode = 1'b1;
    for (int i = 0; i < N_REQ; i++) jobs_left[i] = $urandom_range(1, 4);
    waitIdle("random", 5000);
    random_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
